// File: rtl/l2_fwd_ctrl_if.sv
// l2_fwd_ctrl_if
//   FIFO-side bus of the L2 forwarding controller. All FIFOs are
//   first-word-fall-through: dout is valid while empty=0, rden pops.
//   h_fifo_*  : header FIFO (115-bit entry per frame), controller pops
//   b_fifo_*  : body byte FIFO, del marks the last byte of a frame
//   o_fifo_*  : shared egress byte/del with per-port write enables, per-port almost-full
//   master    : controller side, slave : FIFO side
interface l2_fwd_ctrl_if;
   logic [114:0] h_fifo_dout;
   logic         h_fifo_empty;
   logic         h_fifo_rden;
   logic [7:0]   b_fifo_dout;
   logic         b_fifo_empty;
   logic         b_fifo_del;
   logic         b_fifo_rden;
   logic [7:0]   o_fifo_din;
   logic [3:0]   o_fifo_wren;
   logic         o_fifo_del;
   logic [3:0]   o_fifo_afull;

   modport master (
      input  h_fifo_dout, h_fifo_empty,
      output h_fifo_rden,
      input  b_fifo_dout, b_fifo_empty, b_fifo_del,
      output b_fifo_rden,
      output o_fifo_din, o_fifo_wren, o_fifo_del,
      input  o_fifo_afull
   );

   modport slave (
      output h_fifo_dout, h_fifo_empty,
      input  h_fifo_rden,
      output b_fifo_dout, b_fifo_empty, b_fifo_del,
      input  b_fifo_rden,
      input  o_fifo_din, o_fifo_wren, o_fifo_del,
      output o_fifo_afull
   );
endinterface

// File: rtl/l2_fwd_ctrl.sv
// l2_fwd_ctrl
//   Forwarding controller for the 4-port L2 switch. Pops one header entry
//   per frame, learns SRC MAC -> ingress port in a small fully-associative
//   table, looks up DST to build an egress port mask, then drains the frame
//   body into the selected egress FIFOs or discards it.
// Ports:
//   clk, arst   : clock, asynchronous active-high reset
//   bus         : header/body/egress FIFO signals (l2_fwd_ctrl_if.master)
//   fwd_cnt     : frames forwarded (wraps)
//   drop_cnt    : frames dropped (wraps)
module l2_fwd_ctrl #(
   parameter int MAC_ENTRIES = 8
) (
   input  logic              clk,
   input  logic              arst,
   l2_fwd_ctrl_if.master     bus,
   output logic [15:0]       fwd_cnt,
   output logic [15:0]       drop_cnt
);
   localparam int PW = (MAC_ENTRIES > 1) ? $clog2(MAC_ENTRIES) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_WAIT = 3'd2,
      S_FWD  = 3'd3, S_DROP   = 3'd4, S_DONE = 3'd5
   } state_t;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] typ;
      logic [1:0]  port;
      logic        fcs_ok;
   } hdr_t;

   state_t state, state_nxt;
   hdr_t   hdr_q;
   logic [3:0] mask, mask_q;

   logic [MAC_ENTRIES-1:0]       tbl_vld;
   logic [MAC_ENTRIES-1:0][47:0] tbl_mac;
   logic [MAC_ENTRIES-1:0][1:0]  tbl_port;
   logic [PW-1:0]                victim;

   logic          dst_hit, src_hit;
   logic [1:0]    dst_port;
   logic [PW-1:0] src_idx;
   logic          learn, h_take, pop, fwd_inc, drop_inc;
   logic          h_rden_q, del_q;
   logic [7:0]    din_q;
   logic [3:0]    wren_q;

   // TYPE travels with the header but plays no part in forwarding.
   logic unused_typ;
   assign unused_typ = ^hdr_q.typ;

   // Table search on registered contents: a learn write in the same
   // LOOKUP cycle is not visible to the DST lookup.
   always_comb begin
      dst_hit  = 1'b0;
      dst_port = 2'd0;
      src_hit  = 1'b0;
      src_idx  = '0;
      for (int i = 0; i < MAC_ENTRIES; i++) begin
         if (tbl_vld[i] && tbl_mac[i] == hdr_q.dst && !dst_hit) begin
            dst_hit  = 1'b1;
            dst_port = tbl_port[i];
         end
         if (tbl_vld[i] && tbl_mac[i] == hdr_q.src && !src_hit) begin
            src_hit = 1'b1;
            src_idx = PW'(i);
         end
      end
   end

   // Bit 40 is the I/G bit of the first MAC byte; multicast/miss floods.
   always_comb begin
      mask = 4'h0;
      if (hdr_q.dst[40] || !dst_hit)
         mask = 4'hF & ~(4'b0001 << hdr_q.port);
      else if (dst_port != hdr_q.port)
         mask = 4'b0001 << dst_port;
   end

   assign learn = (state == S_LOOKUP) && hdr_q.fcs_ok && !hdr_q.src[40];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      h_take    = 1'b0;
      pop       = 1'b0;
      fwd_inc   = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         S_IDLE: if (!bus.h_fifo_empty) begin
            h_take    = 1'b1;
            state_nxt = S_LOOKUP;
         end
         S_LOOKUP: if (!hdr_q.fcs_ok || mask == 4'h0) begin
            drop_inc  = 1'b1;
            state_nxt = S_DROP;
         end else begin
            state_nxt = S_WAIT;
         end
         // Egress space is checked once per frame, never mid-frame.
         S_WAIT: if ((bus.o_fifo_afull & mask_q) == 4'h0) state_nxt = S_FWD;
         S_FWD: if (!bus.b_fifo_empty) begin
            pop = 1'b1;
            if (bus.b_fifo_del) begin
               fwd_inc   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DROP: if (!bus.b_fifo_empty) begin
            pop = 1'b1;
            if (bus.b_fifo_del) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_DONE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         h_rden_q <= 1'b0;
         hdr_q    <= '0;
         mask_q   <= 4'h0;
         din_q    <= 8'h00;
         wren_q   <= 4'h0;
         del_q    <= 1'b0;
         fwd_cnt  <= 16'd0;
         drop_cnt <= 16'd0;
      end else begin
         h_rden_q <= h_take;
         if (h_take) hdr_q <= hdr_t'(bus.h_fifo_dout);
         if (state == S_LOOKUP) mask_q <= mask;
         // Egress carries the byte popped in the previous cycle.
         din_q  <= (pop && state == S_FWD) ? bus.b_fifo_dout : 8'h00;
         wren_q <= (pop && state == S_FWD) ? mask_q : 4'h0;
         del_q  <= pop && (state == S_FWD) && bus.b_fifo_del;
         if (fwd_inc)  fwd_cnt  <= fwd_cnt + 16'd1;
         if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         tbl_vld  <= '0;
         tbl_mac  <= '0;
         tbl_port <= '0;
         victim   <= '0;
      end else if (learn) begin
         if (src_hit) begin
            tbl_port[src_idx] <= hdr_q.port;
         end else begin
            tbl_vld[victim]  <= 1'b1;
            tbl_mac[victim]  <= hdr_q.src;
            tbl_port[victim] <= hdr_q.port;
            victim           <= victim + 1'b1;
         end
      end
   end

   assign bus.h_fifo_rden = h_rden_q;
   assign bus.b_fifo_rden = pop;
   assign bus.o_fifo_din  = din_q;
   assign bus.o_fifo_wren = wren_q;
   assign bus.o_fifo_del  = del_q;
endmodule

// File: tb/tb_l2_fwd_ctrl.sv
// tb_l2_fwd_ctrl
//   Directed bench for l2_fwd_ctrl: FWFT header/body FIFO models, an
//   egress write logger, and hand-computed expected masks and counters.
module tb_l2_fwd_ctrl;
   logic clk = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   l2_fwd_ctrl_if bus();
   logic [15:0] fwd_cnt, drop_cnt;

   l2_fwd_ctrl #(.MAC_ENTRIES(8)) dut (
      .clk(clk), .arst(arst), .bus(bus), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
   );

   // FIFO models
   logic [114:0] hmem [0:63];
   logic [5:0]   hwr = '0, hrd;
   logic [7:0]   bmem [0:4095];
   logic         bdel [0:4095];
   logic [11:0]  bwr = '0, brd;
   int           cyc = 0;
   logic         stall_en = 1'b0;
   logic [3:0]   afull = 4'h0;

   assign bus.h_fifo_empty = (hrd == hwr);
   assign bus.h_fifo_dout  = hmem[hrd];
   assign bus.b_fifo_empty = (brd == bwr) | (stall_en & cyc[1]);
   assign bus.b_fifo_dout  = bmem[brd];
   assign bus.b_fifo_del   = bdel[brd];
   assign bus.o_fifo_afull = afull;

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         hrd <= hwr;
         brd <= bwr;
      end else begin
         if (bus.h_fifo_rden) hrd <= hrd + 6'd1;
         if (bus.b_fifo_rden) brd <= brd + 12'd1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Egress logger
   logic [7:0] lg_b [0:4095];
   logic [3:0] lg_w [0:4095];
   logic       lg_d [0:4095];
   int         lg_c [0:4095];
   int         lg_n = 0;
   int         hrd_cyc = 0;

   always @(negedge clk) begin
      if (bus.o_fifo_wren != 4'h0 && lg_n < 4096) begin
         lg_b[lg_n] <= bus.o_fifo_din;
         lg_w[lg_n] <= bus.o_fifo_wren;
         lg_d[lg_n] <= bus.o_fifo_del;
         lg_c[lg_n] <= cyc;
         lg_n       <= lg_n + 1;
      end
      if (bus.h_fifo_rden) hrd_cyc <= cyc;
   end

   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] port,
                             input logic fcs, input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) begin
         bmem[bwr] = 8'(seed + 8'(i));
         bdel[bwr] = (i == n - 1);
         bwr       = bwr + 12'd1;
      end
      hmem[hwr] = {dst, src, 16'h0800, port, fcs};
      hwr       = hwr + 6'd1;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while (!(hrd == hwr && brd == bwr) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check({tag, " timeout"}, 1, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int base, input int n, input logic [7:0] seed,
                              input logic [3:0] mask);
      int cnt, bad;
      cnt = lg_n - base;
      bad = 0;
      check({tag, " nwr"}, cnt, (mask == 4'h0) ? 0 : n);
      for (int i = 0; i < cnt; i++) begin
         if (lg_w[base+i] !== mask || lg_b[base+i] !== 8'(seed + 8'(i)) ||
             lg_d[base+i] !== (i == cnt - 1))
            bad++;
      end
      check({tag, " data"}, bad, 0);
   endtask

   task automatic run_frame(input string tag, input logic [47:0] dst, input logic [47:0] src,
                            input logic [1:0] port, input logic fcs, input int n,
                            input logic [7:0] seed, input logic [3:0] mask);
      int base;
      base = lg_n;
      push_frame(dst, src, port, fcs, n, seed);
      wait_done(tag);
      check_frame(tag, base, n, seed, mask);
   endtask

   localparam logic [47:0] BC     = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] M1     = 48'h0200_0000_0001;
   localparam logic [47:0] M2     = 48'h0200_0000_0002;
   localparam logic [47:0] M3     = 48'h0200_0000_0003;
   localparam logic [47:0] M4     = 48'h0200_0000_0004;
   localparam logic [47:0] MC_SRC = 48'h0100_0000_00AA;
   localparam logic [47:0] XMAC   = 48'h0200_0000_ABCD;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, t;
      logic [11:0] bstart;

      repeat (3) @(negedge clk);
      check("rst h_rden", bus.h_fifo_rden, 0);
      check("rst b_rden", bus.b_fifo_rden, 0);
      check("rst din",    bus.o_fifo_din, 0);
      check("rst wren",   bus.o_fifo_wren, 0);
      check("rst del",    bus.o_fifo_del, 0);
      check("rst fwd",    fwd_cnt, 0);
      check("rst drop",   drop_cnt, 0);
      arst = 1'b0;
      @(negedge clk);

      // Broadcast from port 0, 64 bytes: flood to 1,2,3; LOOKUP->DONE is N+2 cycles
      base = lg_n;
      push_frame(BC, M1, 2'd0, 1'b1, 64, 8'h00);
      wait_done("A");
      check_frame("A", base, 64, 8'h00, 4'b1110);
      check("A lat", lg_c[lg_n-1] - hrd_cyc, 66);
      check("A fwd_cnt", fwd_cnt, 1);

      // Unicast to learned M1 (port 0) from port 2, with body stalls
      stall_en = 1'b1;
      run_frame("B", M1, M2, 2'd2, 1'b1, 16, 8'h40, 4'b0001);
      stall_en = 1'b0;

      // DST on ingress port: drop, all bytes popped
      run_frame("C", M1, M3, 2'd0, 1'b1, 10, 8'h80, 4'b0000);
      check("C popped", brd, bwr);
      check("C drop_cnt", drop_cnt, 1);
      check("C fwd_cnt", fwd_cnt, 2);

      // Bad FCS: dropped, M4 not learned
      run_frame("D", M2, M4, 2'd1, 1'b0, 5, 8'hA0, 4'b0000);
      check("D drop_cnt", drop_cnt, 2);

      // To M4 from port 3: floods to 0,1,2
      run_frame("E", M4, M1, 2'd3, 1'b1, 6, 8'hB0, 4'b0111);
      check("E fwd_cnt", fwd_cnt, 3);

      // Egress port 3 almost full: hold in WAIT, then start one cycle after release
      afull  = 4'b1000;
      base   = lg_n;
      bstart = bwr;
      push_frame(BC, M3, 2'd0, 1'b1, 8, 8'h60);
      repeat (20) @(negedge clk);
      check("F hold pops", brd, bstart);
      check("F hold wr", lg_n - base, 0);
      check("F hdr taken", hrd == hwr, 1);
      check("F rden low", bus.b_fifo_rden, 0);
      afull = 4'h0;
      @(negedge clk);
      check("F rden start", bus.b_fifo_rden, 1);
      wait_done("F");
      check_frame("F", base, 8, 8'h60, 4'b1110);
      check("F fwd_cnt", fwd_cnt, 4);

      // Reset mid-FWD
      base = lg_n;
      push_frame(BC, M3, 2'd0, 1'b1, 64, 8'h10);
      t = 0;
      while (lg_n - base < 5 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("G start timeout", 1, 0);
      arst = 1'b1;
      #1;
      check("G h_rden", bus.h_fifo_rden, 0);
      check("G b_rden", bus.b_fifo_rden, 0);
      check("G din",    bus.o_fifo_din, 0);
      check("G wren",   bus.o_fifo_wren, 0);
      check("G del",    bus.o_fifo_del, 0);
      check("G fwd",    fwd_cnt, 0);
      check("G drop",   drop_cnt, 0);
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);

      // Table cleared: M1 (last seen on port 3) now floods
      run_frame("H", M1, MC_SRC, 2'd2, 1'b1, 4, 8'hC0, 4'b1011);
      check("H fwd_cnt", fwd_cnt, 1);

      // Nine distinct SRCs from port 1: the ninth overwrites entry 0
      for (int k = 0; k < 9; k++)
         run_frame($sformatf("L%0d", k), BC, 48'h0200_0000_1000 + 48'(k), 2'd1, 1'b1, 2,
                   8'(k * 8), 4'b1101);
      run_frame("W0", 48'h0200_0000_1000, MC_SRC, 2'd2, 1'b1, 3, 8'hD0, 4'b1011);
      run_frame("W1", 48'h0200_0000_1001, MC_SRC, 2'd2, 1'b1, 3, 8'hE0, 4'b0010);

      // DST equal to SRC being learned in the same cycle: pre-write lookup floods
      run_frame("X0", XMAC, XMAC, 2'd1, 1'b1, 3, 8'hF0, 4'b1101);
      run_frame("X1", XMAC, MC_SRC, 2'd2, 1'b1, 3, 8'h33, 4'b0010);
      check("end fwd_cnt", fwd_cnt, 14);
      check("end drop_cnt", drop_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/l2_fwd_ctrl.md
# l2_fwd_ctrl

Forwarding controller for the 4-port L2 switch. It consumes the per-frame header entries and byte stream written by the MAC decoder into the shared header and body FIFOs. It learns source MAC to ingress port mappings in a small fully-associative table and looks up the destination port. It then drains the frame body into the selected egress FIFO(s), or discards it.

## Interface
Parameters:
- MAC_ENTRIES, 8, learning-table depth (power of 2, 2..16)

Ports (name, direction, width, meaning):
- clk  in  1  single system clock
- arst  in  1  asynchronous, active-high reset
- h_fifo_dout  in  115  header entry, fields listed below
  - [114:67] DST MAC, first byte in [114:107]
  - [66:19] SRC MAC
  - [18:3] TYPE
  - [2:1] ingress port
  - [0] fcs_ok
- h_fifo_empty  in  1  header FIFO empty
- h_fifo_rden  out  1  header pop
- b_fifo_dout  in  8  body byte
- b_fifo_empty  in  1  body FIFO empty
- b_fifo_del  in  1  current b_fifo_dout is the last byte of the frame
- b_fifo_rden  out  1  body pop
- o_fifo_din  out  8  byte to egress FIFOs (shared)
- o_fifo_wren  out  4  per-port write enable
- o_fifo_del  out  1  delimiter tag written with the byte
- o_fifo_afull  in  4  per-port: fewer than 1514 B free
- fwd_cnt  out  16  frames forwarded, wraps
- drop_cnt  out  16  frames dropped, wraps

## Operation
- All FIFOs are first-word-fall-through: dout is valid while empty=0, and rden pops the entry.
- Each header entry corresponds to exactly one body frame, terminated by del.
- A MAC is multicast when bit 40 of the field is 1 (I/G bit of the first byte). Broadcast is a case of multicast.
- Learning table: MAC_ENTRIES × {valid, mac[47:0], port[1:0]}. Replacement uses a round-robin victim pointer, log2(MAC_ENTRIES) bits, wrapping.
- States and transitions:
  - IDLE: if h_fifo_empty=0, latch h_fifo_dout, pulse h_fifo_rden for 1 cycle, go to LOOKUP.
  - LOOKUP (1 cycle):
    - Destination lookup uses the table contents before this cycle's learn write.
    - Mask rules:
      - DST multicast or DST miss → mask = 4'hF with the ingress bit cleared.
      - DST hit, port ≠ ingress → mask = 1<<port.
      - DST hit, port = ingress → mask = 0.
    - Learn only when fcs_ok=1 and SRC is unicast:
      - SRC hit → overwrite that entry's port.
      - SRC miss → write the victim entry (valid=1) and advance the pointer.
    - Next state: fcs_ok=0 or mask=0 → DROP (drop_cnt+1). Otherwise → WAIT.
  - WAIT: when (o_fifo_afull & mask)==0, go to FWD. The check is made once per frame. Egress FIFOs are not rechecked mid-frame.
  - FWD: each cycle with b_fifo_empty=0, pop a byte and write it to every port in mask. When the popped byte has b_fifo_del=1, go to DONE and increment fwd_cnt.
  - DROP: pop bytes without writing. When the popped byte has b_fifo_del=1, go to DONE.
  - DONE: one cycle, go to IDLE.
  - Any undefined encoding goes to DONE.
- Reset (asserted at any time, including mid-frame):
  - State returns to IDLE and all table valid bits and the victim pointer clear.
  - Counters go to 0 and all outputs deassert.
  - A partially drained frame is not resumed; the FIFOs are reset by the same arst.

## Timing
- Reset values: h_fifo_rden=0, b_fifo_rden=0, o_fifo_din=0, o_fifo_wren=0, o_fifo_del=0, fwd_cnt=0, drop_cnt=0.
- h_fifo_rden is registered: high for exactly the cycle after IDLE sees h_fifo_empty=0.
- b_fifo_rden is combinational: (state==FWD or state==DROP) & ~b_fifo_empty.
- o_fifo_din, o_fifo_wren and o_fifo_del are registered: they carry the byte popped in the previous cycle. o_fifo_wren=0 in every cycle without a pop in FWD.
- An empty body FIFO mid-frame stalls the transfer with no byte loss and no duplicate.
- Minimum overhead per frame, with the body already present and egress not full: IDLE, LOOKUP, WAIT, then N FWD cycles, then DONE. That is N+4 cycles for an N-byte body.
- The last egress write (del=1) occurs in the DONE cycle.
- Simultaneous learn of SRC and lookup of an identical DST in the same LOOKUP cycle resolves to the pre-write table contents.

## Test plan
- Reset, then a frame from port 0: DST=FF:FF:FF:FF:FF:FF, SRC=02:00:00:00:00:01, fcs_ok=1, 64-byte body → o_fifo_wren=4'b1110 for 64 cycles, last byte with del=1, fwd_cnt=1. The table learns SRC→port 0.
- Then a frame from port 2 with DST=02:00:00:00:00:01 → only o_fifo_wren[0] is ever set; byte order and values match the body exactly.
- Frame from port 0 with DST=02:00:00:00:00:01 (hit on the ingress port) → 0 writes, all bytes popped, drop_cnt increments by 1.
- Frame with fcs_ok=0 → dropped and SRC not learned. A subsequent frame to that SRC floods, with wren = 4'hF minus the ingress bit.
- o_fifo_afull[3]=1 on a flood from port 0 → controller holds in WAIT with no pops. Deassert after 20 cycles → transfer starts 1 cycle later.
- Learn MAC_ENTRIES+1 distinct SRCs → entry 0 is overwritten (wrap) and the first MAC floods again. Assert arst mid-FWD → all outputs 0 next edge and the table is empty.
